// File: rtl/hnf_txreq_queue_pkg.sv
// Shared types and constants for the HNF TXREQ queue: the CHI request flit
// layout and the default node IDs stamped onto outgoing requests.
package hnf_txreq_queue_pkg;

  localparam int CHI_MAX_LCRD = 15;

  localparam logic [6:0] HNF_NODE_ID_DEF = 7'h00;
  localparam logic [6:0] SNF_NODE_ID_DEF = 7'h10;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
  } reqflit_t;

endpackage

// File: rtl/hnf_txreq_queue_if.sv
// Request-in and TXREQ-out handshakes plus the L-credit grant of the queue.
// Valid/ready: a transfer happens on a posedge where valid and ready are both
// high; a source must not make valid depend on ready in the same cycle.
interface hnf_txreq_queue_if;
  import hnf_txreq_queue_pkg::*;

  reqflit_t req_in;
  logic     req_in_valid;
  logic     req_in_ready;
  logic     lcrd_grant;
  reqflit_t txreqflit;
  logic     txreq_valid;
  logic     txreq_ready;

  modport master (
    output req_in, req_in_valid, lcrd_grant, txreq_ready,
    input  req_in_ready, txreqflit, txreq_valid
  );

  modport slave (
    input  req_in, req_in_valid, lcrd_grant, txreq_ready,
    output req_in_ready, txreqflit, txreq_valid
  );
endinterface

// File: rtl/hnf_txreq_queue_chi_flit_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; full/empty come from
// pointer compare, count from pointer difference.
module chi_flit_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  T                         push_data_i,
  input  logic                     pop_i,
  output T                         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Guard here too so a careless caller can never corrupt the pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/hnf_txreq_queue.sv
// Buffers ReadNoSnp flits from the HNF pipeline and releases one per CHI
// TXREQ L-credit held, stamping SrcID/TgtID on the way out.
module hnf_txreq_queue
  import hnf_txreq_queue_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         MAX_LCRD    = CHI_MAX_LCRD,
  parameter logic [6:0] HNF_NODE_ID = HNF_NODE_ID_DEF,
  parameter logic [6:0] SNF_NODE_ID = SNF_NODE_ID_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  hnf_txreq_queue_if.slave                bus,
  output logic [$clog2(MAX_LCRD+1)-1:0]   lcrd_cnt,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy,
  output logic                            lcrd_overflow
);
  localparam int LW = $clog2(MAX_LCRD + 1);
  localparam logic [LW-1:0] CNT_ONE = 1;

  reqflit_t        head_flit;
  reqflit_t        out_flit;
  logic            fifo_full;
  logic            fifo_empty;
  logic            issue;
  logic [LW-1:0]   lcrd_cnt_q, lcrd_cnt_d;
  logic            lcrd_overflow_q, lcrd_overflow_d;

  chi_flit_fifo #(
    .T     (reqflit_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (bus.req_in_valid && !fifo_full),
    .push_data_i (bus.req_in),
    .pop_i       (issue),
    .pop_data_o  (head_flit),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (occupancy)
  );

  // No push-on-pop when full: ready depends on registered state only.
  assign bus.req_in_ready = !fifo_full;
  assign bus.txreq_valid  = !fifo_empty && (lcrd_cnt_q != '0);
  assign issue            = bus.txreq_valid && bus.txreq_ready;

  always_comb begin
    out_flit        = head_flit;
    out_flit.src_id = HNF_NODE_ID;
    out_flit.tgt_id = SNF_NODE_ID;
  end
  assign bus.txreqflit = out_flit;

  always_comb begin
    lcrd_cnt_d      = lcrd_cnt_q;
    lcrd_overflow_d = lcrd_overflow_q;
    if (bus.lcrd_grant && !issue) begin
      if (lcrd_cnt_q == LW'(MAX_LCRD)) lcrd_overflow_d = 1'b1;
      else                             lcrd_cnt_d = lcrd_cnt_q + CNT_ONE;
    end else if (!bus.lcrd_grant && issue) begin
      lcrd_cnt_d = lcrd_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lcrd_cnt_q      <= '0;
      lcrd_overflow_q <= 1'b0;
    end else begin
      lcrd_cnt_q      <= lcrd_cnt_d;
      lcrd_overflow_q <= lcrd_overflow_d;
    end
  end

  assign lcrd_cnt      = lcrd_cnt_q;
  assign lcrd_overflow = lcrd_overflow_q;
endmodule

// File: tb/tb_hnf_txreq_queue.sv
// Bench for hnf_txreq_queue: directed steps plus a random phase, all checked
// against a queue-and-counter reference model of the credit-gated queue.
module tb_hnf_txreq_queue;
  import hnf_txreq_queue_pkg::*;

  localparam int         DEPTH    = 4;
  localparam int         MAX_LCRD = 15;
  localparam logic [6:0] HNF_ID   = 7'h00;
  localparam logic [6:0] SNF_ID   = 7'h10;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] lcrd_cnt;
  logic [2:0] occupancy;
  logic       lcrd_overflow;

  always #5 clock = ~clock;

  hnf_txreq_queue_if bus_if ();

  hnf_txreq_queue #(
    .DEPTH       (DEPTH),
    .MAX_LCRD    (MAX_LCRD),
    .HNF_NODE_ID (HNF_ID),
    .SNF_NODE_ID (SNF_ID)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus_if),
    .lcrd_cnt      (lcrd_cnt),
    .occupancy     (occupancy),
    .lcrd_overflow (lcrd_overflow)
  );

  // scoreboard / reference model
  int       checks = 0;
  int       errors = 0;
  reqflit_t exp_q[$];
  int       exp_cred = 0;
  bit       exp_ovf  = 1'b0;
  reqflit_t pushed[5];

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic reqflit_t stamp(reqflit_t f);
    reqflit_t s = f;
    s.src_id = HNF_ID;
    s.tgt_id = SNF_ID;
    return s;
  endfunction

  function automatic reqflit_t rand_flit();
    reqflit_t f;
    f.qos          = 4'($urandom_range(0, 15));
    f.tgt_id       = 7'($urandom_range(0, 127));
    f.src_id       = 7'($urandom_range(0, 127));
    f.txn_id       = 8'($urandom_range(0, 255));
    f.opcode       = 6'($urandom_range(0, 63));
    f.size         = 3'($urandom_range(0, 7));
    f.addr[47:32]  = 16'($urandom_range(0, 65535));
    f.addr[31:0]   = $urandom;
    return f;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus_if.req_in       = '0;
    bus_if.req_in_valid = 1'b0;
    bus_if.lcrd_grant   = 1'b0;
    bus_if.txreq_ready  = 1'b0;
  endtask

  // Called at a negedge with inputs set: checks outputs against the model,
  // steps one clock and updates the model from the rules of the queue.
  task automatic cycle();
    bit exp_valid, push, issue;
    #1;
    exp_valid = (exp_q.size() != 0) && (exp_cred != 0);
    check("occupancy", occupancy, exp_q.size());
    check("lcrd_cnt", lcrd_cnt, exp_cred);
    check("lcrd_overflow", lcrd_overflow, exp_ovf);
    check("txreq_valid", bus_if.txreq_valid, exp_valid);
    check("req_in_ready", bus_if.req_in_ready, exp_q.size() < DEPTH);
    if (exp_valid) check("txreqflit", bus_if.txreqflit, stamp(exp_q[0]));
    push  = bus_if.req_in_valid && (exp_q.size() < DEPTH);
    issue = exp_valid && bus_if.txreq_ready;
    @(posedge clock);
    if (issue) void'(exp_q.pop_front());
    if (push) exp_q.push_back(bus_if.req_in);
    if (bus_if.lcrd_grant && !issue) begin
      if (exp_cred == MAX_LCRD) exp_ovf = 1'b1;
      else exp_cred++;
    end else if (!bus_if.lcrd_grant && issue) begin
      exp_cred--;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_cred = 0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    reqflit_t f;
    idle_inputs();
    do_reset();

    // reset state
    check("rst_occ", occupancy, 0);
    check("rst_cnt", lcrd_cnt, 0);
    check("rst_valid", bus_if.txreq_valid, 0);
    check("rst_ready", bus_if.req_in_ready, 1);
    check("rst_ovf", lcrd_overflow, 0);
    cycle();

    // one flit, no credit: stays parked
    f = rand_flit();
    f.addr   = 48'h1000;
    f.txn_id = 8'h05;
    bus_if.req_in = f;
    bus_if.req_in_valid = 1'b1;
    cycle();
    bus_if.req_in_valid = 1'b0;
    repeat (10) cycle();
    check("t1_valid", bus_if.txreq_valid, 0);
    check("t1_occ", occupancy, 1);
    check("t1_cnt", lcrd_cnt, 0);

    // one grant releases it with IDs stamped
    bus_if.lcrd_grant  = 1'b1;
    bus_if.txreq_ready = 1'b1;
    cycle();
    bus_if.lcrd_grant = 1'b0;
    #1;
    check("t2_valid", bus_if.txreq_valid, 1);
    check("t2_addr", bus_if.txreqflit.addr, 48'h1000);
    check("t2_txnid", bus_if.txreqflit.txn_id, 8'h05);
    check("t2_tgtid", bus_if.txreqflit.tgt_id, SNF_ID);
    check("t2_srcid", bus_if.txreqflit.src_id, HNF_ID);
    cycle();
    check("t2_cnt", lcrd_cnt, 0);
    check("t2_occ", occupancy, 0);

    // fill to full with no credits; the fifth flit is held upstream
    bus_if.txreq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pushed[i] = rand_flit();
      bus_if.req_in = pushed[i];
      bus_if.req_in_valid = 1'b1;
      if (i == 4) begin
        #1;
        check("t3_ready_full", bus_if.req_in_ready, 0);
      end
      cycle();
    end
    cycle();
    bus_if.req_in_valid = 1'b0;
    check("t3_occ", occupancy, 4);

    // saturate credits, overflow on the 16th grant
    bus_if.lcrd_grant = 1'b1;
    repeat (15) cycle();
    check("t4_cnt15", lcrd_cnt, 15);
    check("t4_ovf_clear", lcrd_overflow, 0);
    cycle();
    bus_if.lcrd_grant = 1'b0;
    check("t4_cnt_sat", lcrd_cnt, 15);
    check("t4_ovf_set", lcrd_overflow, 1);

    // drain in push order
    bus_if.txreq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_order_addr", bus_if.txreqflit.addr, pushed[i].addr);
      check("t4_order_txnid", bus_if.txreqflit.txn_id, pushed[i].txn_id);
      cycle();
    end
    check("t4_cnt11", lcrd_cnt, 11);
    check("t4_occ0", occupancy, 0);
    check("t4_ovf_sticky", lcrd_overflow, 1);

    // same-cycle grant+issue and push+pop
    do_reset();
    bus_if.req_in_valid = 1'b1;
    bus_if.req_in = rand_flit();
    cycle();
    bus_if.req_in = rand_flit();
    cycle();
    bus_if.req_in_valid = 1'b0;
    bus_if.lcrd_grant = 1'b1;
    cycle();
    check("t5_cnt1", lcrd_cnt, 1);
    check("t5_occ2", occupancy, 2);
    bus_if.lcrd_grant   = 1'b1;
    bus_if.txreq_ready  = 1'b1;
    bus_if.req_in_valid = 1'b1;
    bus_if.req_in       = rand_flit();
    cycle();
    idle_inputs();
    check("t5_cnt_hold", lcrd_cnt, 1);
    check("t5_occ_hold", occupancy, 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus_if.req_in       = rand_flit();
      bus_if.req_in_valid = 1'($urandom_range(0, 1));
      bus_if.lcrd_grant   = ($urandom_range(0, 2) == 0);
      bus_if.txreq_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_inputs();

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus_if.req_in       = rand_flit();
      bus_if.req_in_valid = (i < 3);
      bus_if.lcrd_grant   = 1'b1;
      cycle();
    end
    idle_inputs();
    check("t7_occ3", occupancy, 3);
    check("t7_cnt5", lcrd_cnt, 5);
    do_reset();
    check("t7_rst_occ", occupancy, 0);
    check("t7_rst_cnt", lcrd_cnt, 0);
    check("t7_rst_valid", bus_if.txreq_valid, 0);
    check("t7_rst_ovf", lcrd_overflow, 0);
    repeat (2) cycle();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hnf_txreq_queue.md
Name: hnf_txreq_queue

Overview:
- Buffers ReadNoSnp request flits produced by the HNF request pipeline.
- Tracks CHI TXREQ link-layer credits granted by the SNF.
- Presents one flit per credit to hnf_txreq on its txreqflit/txreq_valid/txreq_ready interface.
- Sits directly upstream of hnf_txreq. Decouples pipeline stalls from link credit availability.

Parameters:
- DEPTH, 4, number of flit entries in the queue; power of 2, at least 2.
- MAX_LCRD, 15, maximum outstanding L-credits held; CHI limit is 15.
- HNF_NODE_ID, 7'h00, value stamped into SrcID of every issued flit.
- SNF_NODE_ID, 7'h10, value stamped into TgtID of every issued flit.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_in  input  reqflit_t  request flit from the HNF pipeline.
- req_in_valid  input  1  req_in holds a valid flit.
- req_in_ready  output  1  queue can accept; equals !full.
- lcrd_grant  input  1  one-cycle L-credit grant from the SNF (TXREQLCRDV).
- txreqflit  output  reqflit_t  head flit with SrcID/TgtID stamped.
- txreq_valid  output  1  head valid and at least one credit held.
- txreq_ready  input  1  hnf_txreq accepts the flit.
- lcrd_cnt  output  $clog2(MAX_LCRD+1)  credits currently held.
- occupancy  output  $clog2(DEPTH+1)  entries in the queue.
- lcrd_overflow  output  1  sticky error flag: a grant arrived while holding MAX_LCRD.

Behaviour:
- Reset values: queue empty, occupancy=0, lcrd_cnt=0, txreq_valid=0, req_in_ready=1 (from the following cycle onward), lcrd_overflow=0. Reset mid-operation discards all queued flits and held credits.
- Push: occurs when req_in_valid & req_in_ready. The flit is written at the write pointer; the pointer advances modulo DEPTH.
- Pop (issue): occurs when txreq_valid & txreq_ready. The read pointer advances modulo DEPTH.
- txreq_valid = (occupancy != 0) & (lcrd_cnt != 0), combinational from registered state only.
- txreqflit = storage[rd_ptr] with SrcID=HNF_NODE_ID and TgtID=SNF_NODE_ID; all other fields pass through unchanged. The value is stable while valid is held and ready is low.
- Latency: a flit pushed in cycle N can issue at the earliest in cycle N+1. There is no bypass path.
- Full: req_in_ready=0 when occupancy==DEPTH, including a cycle in which a pop occurs. There is no same-cycle push-on-pop when full.
- Simultaneous push and pop when not full: occupancy is unchanged and both pointers advance.
- Credit counter:
  - Grant without issue: +1.
  - Issue without grant: -1.
  - Grant and issue in the same cycle: unchanged.
- Grant arriving when lcrd_cnt==MAX_LCRD and no issue occurs that cycle: the count saturates at MAX_LCRD and lcrd_overflow sets. The flag stays set until reset.
- lcrd_cnt never underflows, because issue requires lcrd_cnt != 0.
- The pointers are $clog2(DEPTH) bits plus one wrap bit. Full and empty are derived from pointer equality and the wrap bit.
- Pointers, occupancy, credit count and flag are all registered on posedge clock; only txreq_valid, req_in_ready and txreqflit are combinational outputs.

Decomposition:
- Shared package: reqflit_t (already in the package), CHI_MAX_LCRD=15, plus HNF/SNF node ID constants.
- One natural sub-module, chi_flit_fifo: a generic synchronous FIFO parameterised on type and DEPTH, with push/pop/full/empty/count.
- The credit counter, ID stamping and valid logic stay in hnf_txreq_queue.

Test Plan:
- Reset, then push 1 flit (Addr=48'h1000, TxnID=8'h05) with no grant: txreq_valid stays 0 for 10 cycles, occupancy=1, lcrd_cnt=0.
- Apply 1 grant, txreq_ready=1: txreq_valid=1 in the next cycle with Addr=48'h1000, TgtID=SNF_NODE_ID, SrcID=HNF_NODE_ID. After the issue, lcrd_cnt=0 and occupancy=0.
- Push 5 flits with DEPTH=4 and no credits: req_in_ready=0 after the 4th push, the 5th is held upstream, occupancy=4.
- Grant 15 credits, then a 16th grant: lcrd_cnt=15 and lcrd_overflow=1 (sticky). Then issue 4 queued flits in order: lcrd_cnt=11 and issue order matches push order.
- Same-cycle grant and issue with lcrd_cnt=1: lcrd_cnt stays 1. Same-cycle push and pop at occupancy=2: occupancy stays 2.
- Assert reset mid-stream with occupancy=3 and lcrd_cnt=5: the next cycle shows occupancy=0, lcrd_cnt=0, txreq_valid=0 and lcrd_overflow=0.
